// File: rtl/picosoc_iouart.sv
// picosoc_iouart: buffered 8N1 UART on the PicoSoC iomem bus; define PICOSOC_IOUART_RXFIFO_EN for an RX FIFO instead of a holding register
module picosoc_iouart #(
    parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
    parameter logic [31:0] DEFAULT_DIV = 32'd104,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        ser_tx,
    input  logic        ser_rx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return d < 32'd2 ? 32'd2 : d;
    endfunction

    logic        sel, acc, wr, rd, dat_wr, st_wr, ie_wr;
    logic [1:0]  off, irqen;
    logic [31:0] div;
    logic        txovf, rxovf, ferr;
    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp;
    logic [AW:0] tx_cnt;
    logic        tx_full, tx_empty, tx_acc, tx_pop, tx_busy, tx_tick;
    uart_state_t tx_state, tx_next;
    logic [31:0] tx_div, tx_tcnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    uart_state_t rx_state, rx_next;
    logic        rx_s1, rx_s2, rx_s3, rx_tick, rx_push, ferr_set;
    logic [31:0] rx_div, rx_tcnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh, rx_head;
    logic        rx_valid, rx_pop, rx_ok;
    logic        unused;

    assign unused = &{1'b0, iomem_addr[1:0]};
    assign sel    = iomem_addr[31:4] == BASE_ADDR[31:4];
    assign acc    = iomem_ready && iomem_valid && sel;
    assign off    = iomem_addr[3:2];
    assign wr     = acc && |iomem_wstrb;
    assign rd     = acc && iomem_wstrb == 4'h0;
    assign dat_wr = wr && off == 2'd0 && iomem_wstrb[0];
    assign st_wr  = wr && off == 2'd2 && iomem_wstrb[0];
    assign ie_wr  = wr && off == 2'd3 && iomem_wstrb[0];

    // Bus handshake: one-cycle ready pulse, one cycle after a selected request
    always_ff @(posedge clk) begin
        iomem_ready <= reset ? 1'b0 : sel && iomem_valid && !iomem_ready;
    end

    // Control registers and sticky status bits (a set wins over a same-cycle clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            div   <= DEFAULT_DIV;
            irqen <= 2'b00;
            txovf <= 1'b0;
            rxovf <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (wr && off == 2'd1 && iomem_wstrb[i]) div[8*i +: 8] <= iomem_wdata[8*i +: 8];
            if (ie_wr) irqen <= iomem_wdata[1:0];
            txovf <= (dat_wr && !tx_acc) || (txovf && !(st_wr && iomem_wdata[6]));
            rxovf <= (rx_push && !rx_ok) || (rxovf && !(st_wr && iomem_wdata[3]));
            ferr  <= ferr_set || (ferr && !(st_wr && iomem_wdata[5]));
        end
    end

    // Read mux, driven only during the ready cycle
    always_comb begin
        iomem_rdata = !iomem_ready ? 32'h0 :
                      off == 2'd0 ? (rx_valid ? {24'h0, rx_head} : 32'hFFFF_FFFF) :
                      off == 2'd1 ? div :
                      off == 2'd2 ? {25'h0, txovf, ferr, tx_busy, rxovf, rx_valid, tx_empty, tx_full} :
                                    {30'h0, irqen};
    end

    // Registered level interrupt
    always_ff @(posedge clk) begin
        irq <= reset ? 1'b0 : (irqen[0] && rx_valid) || (irqen[1] && tx_empty && !tx_busy);
    end

    assign tx_full  = tx_cnt == FULL;
    assign tx_empty = tx_cnt == '0;
    assign tx_acc   = dat_wr && (!tx_full || tx_pop);
    assign tx_busy  = tx_state != IDLE;
    assign tx_tick  = tx_tcnt == tx_div - 32'd1;
    assign ser_tx   = tx_state == START ? 1'b0 : tx_state == DATA ? tx_sh[0] : 1'b1;

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (tx_acc) tx_mem[tx_wp] <= iomem_wdata[7:0];
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_acc) tx_wp <= tx_wp + 1'b1;
            if (tx_pop) tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt + {{AW{1'b0}}, tx_acc} - {{AW{1'b0}}, tx_pop};
        end
    end

    // TX state register
    always_ff @(posedge clk) begin
        tx_state <= reset ? IDLE : tx_next;
    end

    // TX next state; the stop bit chains straight into the next start bit when data is waiting
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        if (tx_state == IDLE) begin
            tx_pop  = !tx_empty;
            tx_next = tx_empty ? IDLE : START;
        end else if (tx_tick) begin
            if (tx_state == START) tx_next = DATA;
            else if (tx_state == DATA) tx_next = tx_bit == 3'd7 ? STOP : DATA;
            else begin
                tx_pop  = !tx_empty;
                tx_next = tx_empty ? IDLE : START;
            end
        end
    end

    // TX bit timer and shifter; divider is captured per byte at the pop
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_div  <= 32'd2;
            tx_tcnt <= '0;
            tx_bit  <= '0;
            tx_sh   <= '0;
        end else if (tx_pop) begin
            tx_div  <= clamp_div(div);
            tx_tcnt <= '0;
            tx_bit  <= '0;
            tx_sh   <= tx_mem[tx_rp];
        end else if (tx_busy) begin
            tx_tcnt <= tx_tick ? '0 : tx_tcnt + 32'd1;
            if (tx_tick && tx_state == DATA) begin
                tx_sh  <= tx_sh >> 1;
                tx_bit <= tx_bit + 3'd1;
            end
        end
    end

    assign rx_tick = rx_tcnt == (rx_state == START ? (rx_div >> 1) - 32'd1 : rx_div - 32'd1);

    // RX state register
    always_ff @(posedge clk) begin
        rx_state <= reset ? IDLE : rx_next;
    end

    // RX next state; start is re-checked mid-bit to reject glitches
    always_comb begin
        rx_next  = rx_state;
        rx_push  = 1'b0;
        ferr_set = 1'b0;
        if (rx_state == IDLE) rx_next = !rx_s2 && rx_s3 ? START : IDLE;
        else if (rx_tick) begin
            if (rx_state == START) rx_next = rx_s2 ? IDLE : DATA;
            else if (rx_state == DATA) rx_next = rx_bit == 3'd7 ? STOP : DATA;
            else begin
                rx_next  = IDLE;
                rx_push  = rx_s2;
                ferr_set = !rx_s2;
            end
        end
    end

    // RX synchroniser, bit timer and shifter; divider tracks DIV only while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            {rx_s1, rx_s2, rx_s3} <= 3'b111;
            rx_div  <= 32'd2;
            rx_tcnt <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
        end else begin
            {rx_s1, rx_s2, rx_s3} <= {ser_rx, rx_s1, rx_s2};
            if (rx_state == IDLE) begin
                rx_div  <= clamp_div(div);
                rx_tcnt <= '0;
                rx_bit  <= '0;
            end else begin
                rx_tcnt <= rx_tick ? '0 : rx_tcnt + 32'd1;
                if (rx_tick && rx_state == DATA) begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 3'd1;
                end
            end
        end
    end

`ifdef PICOSOC_IOUART_RXFIFO_EN
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wp, rx_rp;
    logic [AW:0]   rx_cnt;

    assign rx_valid = rx_cnt != '0;
    assign rx_head  = rx_mem[rx_rp];
    assign rx_pop   = rd && off == 2'd0 && rx_valid;
    assign rx_ok    = rx_push && (rx_cnt != FULL || rx_pop);

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (rx_ok) rx_mem[rx_wp] <= rx_sh;
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_ok) rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt + {{AW{1'b0}}, rx_ok} - {{AW{1'b0}}, rx_pop};
        end
    end
`else
    assign rx_pop = rd && off == 2'd0 && rx_valid;
    assign rx_ok  = rx_push && (!rx_valid || rx_pop);

    // RX holding register; a byte landing on a same-cycle read replaces the old one
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid <= 1'b0;
            rx_head  <= '0;
        end else if (rx_ok) begin
            rx_valid <= 1'b1;
            rx_head  <= rx_sh;
        end else if (rx_pop) rx_valid <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_picosoc_iouart.sv
// tb_picosoc_iouart: directed/randomised bench for picosoc_iouart with a serial-line reference model
module tb_picosoc_iouart;
    localparam logic [31:0] B = 32'h0300_0000;

    logic        clk = 1'b0, reset = 1'b1, iomem_valid = 1'b0, ser_rx = 1'b1;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = '0, iomem_wdata = '0;
    logic        iomem_ready, ser_tx, irq;
    logic [31:0] iomem_rdata;

    picosoc_iouart dut (
        .clk(clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata), .ser_tx(ser_tx), .ser_rx(ser_rx), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
        bit got = 0;
        r = 'x;
        iomem_addr = a; iomem_wdata = d; iomem_wstrb = s; iomem_valid = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (iomem_ready) begin got = 1; r = iomem_rdata; end
        end
        chk("bus_ready", 32'(got), 32'd1);
        @(posedge clk); #1;
        chk("ready_pulse", 32'(iomem_ready), 32'd0);
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        bus(a, d, s, dummy);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        bus(a, 32'h0, 4'h0, r);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input int d, input bit stop);
        logic [9:0] f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ser_rx = f[i];
            cycles(d);
        end
        ser_rx = 1'b1;
        cycles(4);
    endtask

    // serial-line monitor: decodes ser_tx frames mid-bit and timestamps each start
    logic [7:0] mon_q[$];
    longint     mon_t[$];
    int         mon_stop_err = 0, tx_div_tb = 4;
    bit         mon_en = 1;
    logic [7:0] mb;
    longint     mt0;
    initial forever begin
        @(negedge clk);
        if (mon_en && !reset && ser_tx === 1'b0) begin
            mt0 = cyc;
            repeat (tx_div_tb / 2) @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                repeat (tx_div_tb) @(negedge clk);
                mb[j] = ser_tx;
            end
            repeat (tx_div_tb) @(negedge clk);
            if (ser_tx !== 1'b1) mon_stop_err++;
            mon_q.push_back(mb);
            mon_t.push_back(mt0);
        end
    end

    task automatic wait_mon(input int n, input int budget);
        for (int i = 0; i < budget && mon_q.size() < n; i++) cycles(1);
        cycles(8);
        chk("mon_count", 32'(mon_q.size()), 32'(n));
    endtask

    logic [31:0] r, r2;
    logic [7:0]  b, exp_q[$];
    logic [9:0]  fr;
    bit          seen;

    initial begin
        cycles(3);
        chk("rst_ready", 32'(iomem_ready), 0);
        chk("rst_rdata", iomem_rdata, 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_ser_tx", 32'(ser_tx), 1);
        reset = 1'b0;
        cycles(1);
        rd(B + 8, r);  chk("rst_status", r, 32'h2);
        rd(B + 4, r);  chk("rst_div", r, 32'd104);
        rd(B + 12, r); chk("rst_irqen", r, 0);
        rd(B, r);      chk("data_empty", r, 32'hFFFF_FFFF);

        iomem_addr = B + 32'h10; iomem_wstrb = 4'h0; iomem_valid = 1'b1; seen = 0;
        repeat (6) begin cycles(1); if (iomem_ready) seen = 1; end
        iomem_valid = 1'b0;
        chk("unsel_ready", 32'(seen), 0);

        r2 = $urandom;
        wr(B + 4, r2, 4'b0101);
        rd(B + 4, r);
        chk("div_strobe", r, (32'd104 & 32'hFF00_FF00) | (r2 & 32'h00FF_00FF));
        wr(B + 4, 32'd4, 4'hF);
        tx_div_tb = 4;

        for (int k = 0; k < 2; k++) begin
            mon_q.delete(); mon_t.delete();
            b = (k == 0) ? 8'h55 : 8'($urandom);
            fr = {1'b1, b, 1'b0};
            wr(B, {24'h0, b}, 4'h1);
            for (int i = 0; i < 6 && ser_tx !== 1'b0; i++) cycles(1);
            for (int i = 0; i < 40; i++) begin
                chk("tx_bit", 32'(ser_tx), 32'(fr[i / 4]));
                cycles(1);
            end
            chk("tx_idle", 32'(ser_tx), 1);
            rd(B + 8, r);
            chk("tx_done_status", r & 32'h13, 32'h02);
            wait_mon(1, 20);
            chk("tx_byte", 32'(mon_q[0]), 32'(b));
        end

        mon_q.delete(); mon_t.delete(); exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom); exp_q.push_back(b);
            wr(B, {24'h0, b}, 4'h1);
        end
        rd(B + 8, r);
        chk("burst_busy", 32'(r[4]), 1);
        chk("burst_txovf", 32'(r[6]), 0);
        wait_mon(9, 600);
        for (int i = 0; i < 9 && i < mon_q.size(); i++) chk("burst_byte", 32'(mon_q[i]), 32'(exp_q[i]));
        for (int i = 1; i < 9 && i < mon_t.size(); i++) chk("burst_gap", 32'(mon_t[i] - mon_t[i-1]), 32'd40);

        mon_q.delete(); mon_t.delete(); exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom); exp_q.push_back(b);
            wr(B, {24'h0, b}, 4'h1);
        end
        rd(B + 8, r);
        chk("ovf_pre", r & 32'h41, 32'h01);
        wr(B, {24'h0, 8'($urandom)}, 4'h1);
        rd(B + 8, r);
        chk("ovf_set", 32'(r[6]), 1);
        wr(B + 8, 32'h40, 4'h1);
        rd(B + 8, r);
        chk("ovf_clear", 32'(r[6]), 0);
        wait_mon(9, 600);
        for (int i = 0; i < 9 && i < mon_q.size(); i++) chk("ovf_byte", 32'(mon_q[i]), 32'(exp_q[i]));
        chk("tx_stop_err", 32'(mon_stop_err), 0);

        wr(B + 4, 32'd8, 4'hF);
        send_rx(8'hA3, 8, 1'b1);
        rd(B + 8, r);  chk("rx_valid", 32'(r[2]), 1);
        rd(B, r);      chk("rx_a3", r, 32'h0000_00A3);
        rd(B, r);      chk("rx_empty", r, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            send_rx(b, 8, 1'b1);
            rd(B, r); chk("rx_rand", r, {24'h0, b});
        end

        send_rx(8'($urandom), 8, 1'b0);
        rd(B + 8, r);  chk("ferr_set", r & 32'h24, 32'h20);
        wr(B + 8, 32'h20, 4'h1);
        rd(B + 8, r);  chk("ferr_clear", r & 32'h24, 32'h00);

        ser_rx = 1'b0; cycles(3); ser_rx = 1'b1; cycles(20);
        rd(B + 8, r);  chk("glitch_flags", r & 32'h2C, 32'h00);
        b = 8'($urandom);
        send_rx(b, 8, 1'b1);
        rd(B, r);      chk("post_glitch", r, {24'h0, b});

        exp_q.delete();
`ifdef PICOSOC_IOUART_RXFIFO_EN
        for (int k = 0; k < 9; k++) begin
            b = 8'($urandom); exp_q.push_back(b);
            send_rx(b, 8, 1'b1);
        end
        rd(B + 8, r);  chk("rxovf_set", r & 32'h0C, 32'h0C);
        for (int k = 0; k < 8; k++) begin
            rd(B, r); chk("rxfifo_byte", r, {24'h0, exp_q[k]});
        end
`else
        for (int k = 0; k < 2; k++) begin
            b = 8'($urandom); exp_q.push_back(b);
            send_rx(b, 8, 1'b1);
        end
        rd(B + 8, r);  chk("rxovf_set", r & 32'h0C, 32'h0C);
        rd(B, r);      chk("rxovf_kept", r, {24'h0, exp_q[0]});
`endif
        rd(B, r);      chk("rxovf_empty", r, 32'hFFFF_FFFF);
        wr(B + 8, 32'h08, 4'h1);
        rd(B + 8, r);  chk("rxovf_clear", 32'(r[3]), 0);

        mon_en = 0;
        wr(B + 12, 32'h1, 4'h1);
        cycles(2);     chk("irq_off", 32'(irq), 0);
        send_rx(8'($urandom), 8, 1'b1);
        chk("irq_rx", 32'(irq), 1);
        rd(B, r);
        chk("irq_lag", 32'(irq), 1);
        cycles(1);     chk("irq_rx_clear", 32'(irq), 0);
        wr(B + 12, 32'h2, 4'h1);
        cycles(2);     chk("irq_txidle", 32'(irq), 1);
        wr(B, 32'h5A, 4'h1);
        cycles(3);     chk("irq_txbusy", 32'(irq), 0);

        cycles(20);
        reset = 1'b1;
        cycles(1);
        chk("rst_mid_tx", 32'(ser_tx), 1);
        chk("rst_mid_irq", 32'(irq), 0);
        reset = 1'b0;
        cycles(1);
        rd(B + 8, r);  chk("rst2_status", r, 32'h2);
        rd(B + 4, r);  chk("rst2_div", r, 32'd104);
        rd(B + 12, r); chk("rst2_irqen", r, 0);
        cycles(20);    chk("rst2_ser_tx", 32'(ser_tx), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
